store_unit: RTL and testbench

Store-side byte-lane unit for the data memory. It accepts a store request (byte, halfword or word, at any byte address) and produces per-lane write data and byte write enables for the four 8-bit memory banks. It is the write counterpart of the load-side lane extractor, which reads the same banks (`data_0..data_3`, byte offset `cs`). Misaligned stores that cross a word boundary are split into two memory beats under a small FSM.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/store_unit_lane_align.sv | 30 +++
 rtl/store_unit.sv | 136 +++++++++++++
 tb/tb_store_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the load-side lane extractor and the store unit.
//   LANES      - number of 8-bit byte lanes / memory banks in a 32-bit word
//   MODE_B/H/W - access-size encodings carried on the request mode field
//   size_mask  - lane mask for an access starting at lane 0 (0 for an illegal mode)
package mem_pkg;

    localparam int LANES = 4;

    localparam logic [2:0] MODE_B = 3'b000;
    localparam logic [2:0] MODE_H = 3'b001;
    localparam logic [2:0] MODE_W = 3'b010;

    function automatic logic [LANES-1:0] size_mask(input logic [2:0] mode);
        logic [LANES-1:0] m;
        case (mode)
            MODE_B:  m = 4'b0001;
            MODE_H:  m = 4'b0011;
            MODE_W:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_unit_lane_align.sv
// store_lane_align: combinational lane steering for a store request.
//   cs_i   [1:0]  byte offset of the store inside its word
//   mode_i [2:0]  access size (MODE_B / MODE_H / MODE_W, others illegal)
//   data_i [31:0] store value, right-justified
//   lane_o [31:0] data rotated left by 8*cs; byte k feeds bank k
//   mask_o [7:0]  two-word enable mask: [3:0] first beat, [7:4] second beat
//                 (all zero for an illegal mode)
module store_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  cs_i,
    input  logic [2:0]  mode_i,
    input  logic [31:0] data_i,
    output logic [31:0] lane_o,
    output logic [7:0]  mask_o
);

    always_comb begin
        // Shifting the size mask across an 8-bit field lets bytes that
        // run past lane 3 land in the upper nibble, i.e. the next word.
        mask_o = {4'b0000, size_mask(mode_i)} << cs_i;
        case (cs_i)
            2'd0:    lane_o = data_i;
            2'd1:    lane_o = {data_i[23:0], data_i[31:24]};
            2'd2:    lane_o = {data_i[15:0], data_i[31:16]};
            default: lane_o = {data_i[7:0],  data_i[31:8]};
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// store_unit: store-side byte-lane unit for the four 8-bit data-memory banks.
// Accepts byte/half/word stores at any byte address, drives per-lane data and
// byte enables, and splits word-crossing stores into two memory beats.
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_addr/data/mode  store address, right-justified data, size
//   mem_req/mem_ack     memory beat valid / single-cycle accept
//   mem_addr            word address of the current beat
//   mem_we              byte enables, bit k = bank k
//   mem_data_0..3       lane data for banks 0..3
//   done / err          one-cycle completion / illegal-mode pulses
module store_unit
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        req_mode,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [29:0]       mem_addr,
    output logic [LANES-1:0]  mem_we,
    output logic [7:0]        mem_data_0,
    output logic [7:0]        mem_data_1,
    output logic [7:0]        mem_data_2,
    output logic [7:0]        mem_data_3,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state_q;
    logic              mem_req_q;
    logic [LANES-1:0]  mem_we_q;
    logic [LANES-1:0]  hi_we_q;
    logic [29:0]       mem_addr_q;
    logic [31:0]       lane_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       lane_w;
    logic [7:0]        mask_w;

    // Alignment is evaluated on the live request so the first beat's
    // enables and lane data can be registered on the accepting edge.
    store_lane_align u_align (
        .cs_i   (req_addr[1:0]),
        .mode_i (req_mode),
        .data_i (req_data),
        .lane_o (lane_w),
        .mask_o (mask_w)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= '0;
            hi_we_q    <= '0;
            mem_addr_q <= '0;
            lane_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (req_valid) begin
                        // A legal size always enables lane cs of the first word.
                        if (mask_w[3:0] != 4'b0000) begin
                            state_q    <= S_BEAT0;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= mask_w[3:0];
                            hi_we_q    <= mask_w[7:4];
                            mem_addr_q <= req_addr[31:2];
                            lane_q     <= lane_w;
                        end else begin
                            state_q <= S_FIN;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_BEAT0: begin
                    if (mem_ack) begin
                        if (hi_we_q != 4'b0000) begin
                            state_q    <= S_BEAT1;
                            mem_we_q   <= hi_we_q;
                            // 30-bit increment wraps the top word to 0.
                            mem_addr_q <= mem_addr_q + 30'd1;
                        end else begin
                            state_q   <= S_FIN;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= '0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ack) begin
                        state_q   <= S_FIN;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= '0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_0 = lane_q[7:0];
    assign mem_data_1 = lane_q[15:8];
    assign mem_data_2 = lane_q[23:16];
    assign mem_data_3 = lane_q[31:24];
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_mode;
    logic        mem_req;
    logic        mem_ack;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [7:0]  mem_data_0;
    logic [7:0]  mem_data_1;
    logic [7:0]  mem_data_2;
    logic [7:0]  mem_data_3;
    logic        done;
    logic        err;

    int tests_run;
    int tests_failed;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] lanes;
    } beat_t;

    beat_t sb_q[$];

    store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_mode   (req_mode),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_data_0 (mem_data_0),
        .mem_data_1 (mem_data_1),
        .mem_data_2 (mem_data_2),
        .mem_data_3 (mem_data_3),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: byte i of the store goes to absolute byte cs+i,
    // which is lane (cs+i)%4 of word addr[31:2] + (cs+i)/4.
    task automatic push_expected(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] mode);
        beat_t b0;
        beat_t b1;
        int n;
        int p;
        n = (mode == 3'b000) ? 1 : (mode == 3'b001) ? 2 : 4;
        b0 = '0;
        b1 = '0;
        b0.addr = addr[31:2];
        b1.addr = addr[31:2] + 30'd1;
        for (int i = 0; i < n; i++) begin
            p = int'(addr[1:0]) + i;
            if (p < 4) begin
                b0.we[p] = 1'b1;
                b0.lanes[p*8 +: 8] = data[i*8 +: 8];
            end else begin
                b1.we[p-4] = 1'b1;
                b1.lanes[(p-4)*8 +: 8] = data[i*8 +: 8];
            end
        end
        sb_q.push_back(b0);
        if (b1.we != 4'b0000) sb_q.push_back(b1);
    endtask

    // Compare one beat cycle against the expected beat; only enabled lanes
    // carry meaningful data.
    task automatic check_beat(input string tag, input beat_t e);
        logic [31:0] obs_l;
        obs_l = {mem_data_3, mem_data_2, mem_data_1, mem_data_0};
        check({tag, ".req"},  32'(mem_req), 32'd1);
        check({tag, ".addr"}, 32'(mem_addr), 32'(e.addr));
        check({tag, ".we"},   32'(mem_we), 32'(e.we));
        for (int k = 0; k < 4; k++) begin
            if (e.we[k]) check($sformatf("%s.lane%0d", tag, k), 32'(obs_l[k*8 +: 8]),
                               32'(e.lanes[k*8 +: 8]));
        end
    endtask

    // Issue a store, serve its beats with `dly` stall cycles each, then
    // check the completion pulse and the return to idle.
    task automatic do_store(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [2:0] mode,
                            input int dly);
        beat_t e;
        int nb;
        push_expected(addr, data, mode);
        nb = sb_q.size();
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_mode  = mode;
        step();
        req_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            e = sb_q.pop_front();
            for (int c = 0; c <= dly; c++) begin
                check_beat($sformatf("%s.b%0d.c%0d", tag, b, c), e);
                check($sformatf("%s.b%0d.c%0d.busy", tag, b, c), 32'(req_ready), 32'd0);
                if (c < dly) begin
                    // A request while busy must be dropped.
                    req_valid = 1'b1;
                    req_addr  = 32'h0000_0F00;
                    req_data  = 32'h5555_5555;
                    req_mode  = 3'b010;
                    mem_ack   = 1'b0;
                end else begin
                    req_valid = 1'b0;
                    mem_ack   = 1'b1;
                end
                step();
            end
            mem_ack = 1'b0;
        end
        check({tag, ".done"},   32'(done), 32'd1);
        check({tag, ".err"},    32'(err), 32'd0);
        check({tag, ".reqlow"}, 32'(mem_req), 32'd0);
        check({tag, ".welow"},  32'(mem_we), 32'd0);
        step();
        check({tag, ".done_end"}, 32'(done), 32'd0);
        check({tag, ".ready_end"}, 32'(req_ready), 32'd1);
        check({tag, ".idle_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_mode  = '0;
        mem_ack   = 1'b0;

        // Reset state
        step();
        step();
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.req",   32'(mem_req), 32'd0);
        check("rst.we",    32'(mem_we), 32'd0);
        check("rst.addr",  32'(mem_addr), 32'd0);
        check("rst.data",  {mem_data_3, mem_data_2, mem_data_1, mem_data_0}, 32'd0);
        check("rst.done",  32'(done), 32'd0);
        check("rst.err",   32'(err), 32'd0);
        rst_n = 1'b1;
        step();

        // Aligned word, immediate ack: done in N+2, ready in N+3
        do_store("sw_aligned", 32'h0000_0100, 32'hB8A6_9482, 3'b010, 0);

        // Byte at every offset
        for (int c = 0; c < 4; c++)
            do_store($sformatf("sb_cs%0d", c), 32'h0000_0200 + 32'(c), 32'h0000_00C3, 3'b000, 0);

        // Aligned half and split half
        do_store("sh_cs2", 32'h0000_0102, 32'h0000_5678, 3'b001, 0);
        do_store("sh_split", 32'h0000_0103, 32'h0000_1234, 3'b001, 0);

        // Split word with a 3-cycle stall per beat
        do_store("sw_stall", 32'h0000_0202, 32'hDEAD_BEEF, 3'b010, 3);
        do_store("sw_cs1", 32'h0000_0301, 32'h0102_0304, 3'b010, 1);
        do_store("sw_cs3", 32'h0000_0303, 32'hA1B2_C3D4, 3'b010, 0);

        // Address wrap on the second beat
        do_store("sw_wrap", 32'hFFFF_FFFD, 32'h1122_3344, 3'b010, 0);

        // Illegal mode: err pulse in N+1, no memory beat, stray ack ignored
        check("ill.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0400;
        req_data  = 32'hFFFF_FFFF;
        req_mode  = 3'b111;
        step();
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        check("ill.err",  32'(err), 32'd1);
        check("ill.done", 32'(done), 32'd0);
        check("ill.req",  32'(mem_req), 32'd0);
        check("ill.we",   32'(mem_we), 32'd0);
        step();
        mem_ack = 1'b0;
        check("ill.err_end", 32'(err), 32'd0);
        check("ill.ready_end", 32'(req_ready), 32'd1);
        check("ill.req_end", 32'(mem_req), 32'd0);
        step();
        check("ill.no_done", 32'(done), 32'd0);

        // Reset during the second beat of a split half
        req_valid = 1'b1;
        req_addr  = 32'h0000_0503;
        req_data  = 32'h0000_ABCD;
        req_mode  = 3'b001;
        step();
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        check("rmid.b1.we",   32'(mem_we), 32'b0001);
        check("rmid.b1.addr", 32'(mem_addr), 32'h0000_0141);
        rst_n = 1'b0;
        step();
        check("rmid.req",   32'(mem_req), 32'd0);
        check("rmid.we",    32'(mem_we), 32'd0);
        check("rmid.done",  32'(done), 32'd0);
        check("rmid.ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check("rmid.no_done", 32'(done), 32'd0);
        do_store("post_rst", 32'h0000_0601, 32'h0000_007E, 3'b000, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
